// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared TM1638 command codes, reader FSM encoding and key-scan decode
package tm1638_pkg;
  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0 = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON = 8'h88;
  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  typedef enum logic [2:0] {IDLE, CMD, WAIT, READ, GAP} state_t;
  function automatic logic [7:0] decode_keys(input logic [31:0] scan);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i] = scan[8*i];
      k[i+4] = scan[8*i+4];
    end
    return k;
  endfunction
endpackage

// File: rtl/tm1638_key_reader_if.sv
// tm1638_key_reader_if: TM1638 3-wire bus (stb, clk, dio split into out/oe/in); master drives the device
interface tm1638_key_reader_if;
  logic stb, clk, dio_out, dio_oe, dio_in;
  modport master(output stb, clk, dio_out, dio_oe, input dio_in);
  modport slave(input stb, clk, dio_out, dio_oe, output dio_in);
endinterface

// File: rtl/tm1638_bit_timer.sv
// tm1638_bit_timer: half-bit down-counter; phase_end flags the edge where sclk toggles while run is high; sclk parks high when idle
module tm1638_bit_timer #(
  parameter int HALF_CYC = 25
) (
  input  logic _50MHz_CLK,
  input  logic rst_n,
  input  logic run,
  output logic phase_end,
  output logic sclk
);
  localparam int CW = HALF_CYC > 1 ? $clog2(HALF_CYC) : 1;
  logic [CW-1:0] cnt;
  assign phase_end = cnt == '0;
  always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sclk <= 1'b1;
    end else if (!run) begin
      cnt <= '0;
      sclk <= 1'b1;
    end else if (phase_end) begin
      cnt <= CW'(HALF_CYC - 1);
      sclk <= ~sclk;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: sends read-key command 0x42, clocks in 4 scan bytes, decodes 8 keys
// ports: _50MHz_CLK/rst_n clock and async reset; start/busy request; bus = TM1638 master side; raw/keys/keys_valid result
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int HALF_CYC = 25,
  parameter int WAIT_CYC = 100,
  parameter int GAP_CYC = 50
) (
  input  logic        _50MHz_CLK,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  tm1638_key_reader_if.master bus,
  output logic [31:0] raw,
  output logic [7:0]  keys,
  output logic        keys_valid
);
  localparam int WW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  state_t state, state_n;
  logic [5:0] bit_cnt;
  logic [WW-1:0] wcnt;
  logic [GW-1:0] gcnt;
  logic [30:0] sr;
  logic run, phase_end, sclk, last, fall, rise;
  tm1638_bit_timer #(.HALF_CYC(HALF_CYC)) u_timer (
    ._50MHz_CLK(_50MHz_CLK),
    .rst_n(rst_n),
    .run(run),
    .phase_end(phase_end),
    .sclk(sclk)
  );
  assign bus.clk = sclk;
  // bit_cnt steps on each rising clk, so a high phase ending with the full count closes the frame
  assign last = phase_end && sclk && bit_cnt == (state == CMD ? 6'd8 : 6'd32);
  assign fall = run && phase_end && sclk;
  assign rise = run && phase_end && !sclk;
  always_comb begin
    state_n = state;
    run = 1'b0;
    unique case (state)
      IDLE: state_n = start ? CMD : IDLE;
      CMD: begin
        run = !last;
        state_n = last ? WAIT : CMD;
      end
      WAIT: begin
        // the timer runs on the final wait clock so the first read falling edge lands exactly WAIT_CYC after CMD
        run = wcnt == WW'(WAIT_CYC - 1);
        state_n = run ? READ : WAIT;
      end
      READ: begin
        run = !last;
        state_n = last ? GAP : READ;
      end
      GAP: state_n = gcnt == GW'(GAP_CYC - 1) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      wcnt <= '0;
      gcnt <= '0;
      sr <= '0;
      busy <= 1'b0;
      bus.stb <= 1'b1;
      bus.dio_out <= 1'b1;
      bus.dio_oe <= 1'b0;
      raw <= '0;
      keys <= '0;
      keys_valid <= 1'b0;
    end else begin
      keys_valid <= 1'b0;
      bit_cnt <= (state == IDLE || state == WAIT) ? 6'd0 : rise ? bit_cnt + 6'd1 : bit_cnt;
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      gcnt <= state == GAP ? gcnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        bus.stb <= 1'b0;
        bus.dio_oe <= 1'b1;
        busy <= 1'b1;
      end
      if (state == CMD && fall) bus.dio_out <= CMD_READ_KEYS[bit_cnt[2:0]];
      if (state == CMD && last) begin
        bus.dio_oe <= 1'b0;
        bus.dio_out <= 1'b1;
      end
      if (state == READ && last) begin
        raw <= {bus.dio_in, sr};
        keys <= decode_keys({bus.dio_in, sr});
        keys_valid <= 1'b1;
        bus.stb <= 1'b1;
      end else if (state == READ && phase_end && sclk && bit_cnt != 6'd0) begin
        sr <= {bus.dio_in, sr[30:1]};
      end
      if (state == GAP && state_n == IDLE) busy <= 1'b0;
    end
  end
endmodule
